// File: rtl/peripheral_dbg_soc_dii_channel.sv
// Debug interconnect flit definition shared by the ring router blocks.
package peripheral_dbg_soc_dii_channel;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   // Source index encoding used by the gateway mux and its arbiter.
   localparam logic [1:0] SRC_RING  = 2'd0;
   localparam logic [1:0] SRC_LOCAL = 2'd1;
   localparam logic [1:0] SRC_EXT   = 2'd2;

endpackage

// File: rtl/peripheral_dbg_soc_ring_router_gateway_arb.sv
// 3-way round-robin arbiter for the gateway mux. Produces a one-hot grant,
// follows an externally held lock while a worm is in flight, and rotates its
// priority pointer when a packet's last flit is accepted.
module peripheral_dbg_soc_ring_router_gateway_arb
   import peripheral_dbg_soc_dii_channel::*;
#(
   parameter bit RING_PRIORITY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,       // bit index = source index
   input  logic       lock,      // worm in flight, grant is pinned
   input  logic [2:0] lock_gnt,  // one-hot grant held by the worm
   input  logic       pkt_end,   // last flit of the granted source accepted
   output logic [2:0] gnt
);

   // Index of the source that currently has the highest round-robin priority.
   logic [1:0] ptr_q;
   logic [1:0] gnt_idx;

   function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
      return (idx == SRC_EXT) ? SRC_RING : idx + 2'd1;
   endfunction

   // Grant selection: lock first, then optional ring priority, then round-robin.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      gnt   = '0;
      cand  = ptr_q;
      found = 1'b0;
      if (lock) begin
         gnt = lock_gnt;
      end else if (RING_PRIORITY && req[SRC_RING]) begin
         gnt[SRC_RING] = 1'b1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            // With ring priority the ring never competes in the rotation.
            if (!found && req[cand] && !(RING_PRIORITY && (cand == SRC_RING))) begin
               gnt[cand] = 1'b1;
               found     = 1'b1;
            end
            cand = wrap_inc(cand);
         end
      end
   end

   // Encode the one-hot grant back to a source index for the pointer update.
   always_comb begin
      gnt_idx = SRC_RING;
      if (gnt[SRC_EXT]) begin
         gnt_idx = SRC_EXT;
      end else if (gnt[SRC_LOCAL]) begin
         gnt_idx = SRC_LOCAL;
      end
   end

   // Finished source drops to lowest priority: the next one in order leads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= SRC_RING;
      end else if (pkt_end) begin
         ptr_q <= wrap_inc(gnt_idx);
      end
   end

endmodule

// File: rtl/peripheral_dbg_soc_ring_router_gateway_mux.sv
// Egress merge of a gateway ring router: pass-through ring, local endpoint and
// external gateway share one outgoing ring link. Packets are forwarded as
// whole worms; the output is a single registered flit buffer.
module peripheral_dbg_soc_ring_router_gateway_mux
   import peripheral_dbg_soc_dii_channel::*;
#(
   parameter bit RING_PRIORITY = 1'b1
) (
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in_ring,
   output logic    in_ring_ready,
   input  dii_flit in_local,
   output logic    in_local_ready,
   input  dii_flit in_ext,
   output logic    in_ext_ready,
   output dii_flit out_ring,
   input  logic    out_ring_ready
);

   typedef enum logic {
      StIdle,
      StWorm
   } state_e;

   state_e     state_q;
   logic [2:0] lock_q;
   dii_flit    out_q;
   dii_flit    out_d;

   logic [2:0] req;
   logic [2:0] gnt;
   dii_flit    sel_flit;
   logic       load_en;
   logic       accept;
   logic       pkt_end;

   assign req = {in_ext.valid, in_local.valid, in_ring.valid};

   // The buffer can take a flit when empty or when its flit leaves this cycle.
   assign load_en = !out_q.valid || out_ring_ready;

   peripheral_dbg_soc_ring_router_gateway_arb #(
      .RING_PRIORITY (RING_PRIORITY)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .lock     (state_q == StWorm),
      .lock_gnt (lock_q),
      .pkt_end  (pkt_end),
      .gnt      (gnt)
   );

   // Readies are held low for as long as reset is asserted.
   assign in_ring_ready  = gnt[SRC_RING]  && load_en && !rst;
   assign in_local_ready = gnt[SRC_LOCAL] && load_en && !rst;
   assign in_ext_ready   = gnt[SRC_EXT]   && load_en && !rst;

   // Flit mux driven by the one-hot grant.
   always_comb begin
      sel_flit = '0;
      unique case (gnt)
         3'b001:  sel_flit = in_ring;
         3'b010:  sel_flit = in_local;
         3'b100:  sel_flit = in_ext;
         default: sel_flit = '0;
      endcase
   end

   assign accept  = sel_flit.valid && load_en && !rst;
   assign pkt_end = accept && sel_flit.last;

   // Next output buffer contents: new flit on accept, drain on an empty load.
   always_comb begin
      out_d = out_q;
      if (load_en) begin
         if (accept) begin
            out_d.valid = 1'b1;
            out_d.last  = sel_flit.last;
            out_d.data  = sel_flit.data;
         end else begin
            out_d.valid = 1'b0;
         end
      end
   end

   // Output flit register; out_ring is driven straight from these flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   // Worm FSM: lock the grant after a non-last first flit, release on last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         lock_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept && !sel_flit.last) begin
                  state_q <= StWorm;
                  lock_q  <= gnt;
               end
            end
            StWorm: begin
               if (pkt_end) begin
                  state_q <= StIdle;
                  lock_q  <= '0;
               end
            end
            default: begin
               state_q <= StIdle;
               lock_q  <= '0;
            end
         endcase
      end
   end

   assign out_ring = out_q;

endmodule

// File: tb/tb_peripheral_dbg_soc_ring_router_gateway_mux.sv
// Directed bench for the gateway mux. Instance 0 runs pure round-robin,
// instance 1 runs with ring priority; both share clock and reset.
module tb_peripheral_dbg_soc_ring_router_gateway_mux;
   import peripheral_dbg_soc_dii_channel::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dii_flit ring_f [2];
   dii_flit loc_f  [2];
   dii_flit ext_f  [2];
   dii_flit out_f  [2];
   logic    ring_rdy [2];
   logic    loc_rdy  [2];
   logic    ext_rdy  [2];
   logic    out_rdy  [2];

   int cmp_cnt = 0;
   int err_cnt = 0;

   peripheral_dbg_soc_ring_router_gateway_mux #(
      .RING_PRIORITY (1'b0)
   ) dut0 (
      .clk            (clk),
      .rst            (rst),
      .in_ring        (ring_f[0]),
      .in_ring_ready  (ring_rdy[0]),
      .in_local       (loc_f[0]),
      .in_local_ready (loc_rdy[0]),
      .in_ext         (ext_f[0]),
      .in_ext_ready   (ext_rdy[0]),
      .out_ring       (out_f[0]),
      .out_ring_ready (out_rdy[0])
   );

   peripheral_dbg_soc_ring_router_gateway_mux #(
      .RING_PRIORITY (1'b1)
   ) dut1 (
      .clk            (clk),
      .rst            (rst),
      .in_ring        (ring_f[1]),
      .in_ring_ready  (ring_rdy[1]),
      .in_local       (loc_f[1]),
      .in_local_ready (loc_rdy[1]),
      .in_ext         (ext_f[1]),
      .in_ext_ready   (ext_rdy[1]),
      .out_ring       (out_f[1]),
      .out_ring_ready (out_rdy[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ring_f[i] = '0;
         loc_f[i]  = '0;
         ext_f[i]  = '0;
         out_rdy[i] = 1'b1;
      end
      // Valid requests during reset must still see no ready.
      ring_f[0] = {1'b1, 1'b1, 16'h1234};
      loc_f[1]  = {1'b1, 1'b1, 16'h5678};
      #2;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0], ring_rdy[1], loc_rdy[1], ext_rdy[1]} !== 6'b0) begin
         err_cnt++;
         $display("FAIL reset_ready: got %b%b%b %b%b%b want all 0", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0], ring_rdy[1], loc_rdy[1], ext_rdy[1]);
      end
      tick();
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[1]} !== 2'b00) begin
         err_cnt++;
         $display("FAIL reset_ready_edge: got %b%b want 00", ring_rdy[0], loc_rdy[1]);
      end
      cmp_cnt++;
      if (out_f[0] !== 18'h0 || out_f[1] !== 18'h0) begin
         err_cnt++;
         $display("FAIL reset_out: got %h %h want 0 0", out_f[0], out_f[1]);
      end
      ring_f[0] = '0;
      loc_f[1]  = '0;
      rst = 1'b0;
      tick();
      cmp_cnt++;
      if (out_f[0] !== 18'h0 || out_f[1] !== 18'h0) begin
         err_cnt++;
         $display("FAIL idle_out: got %h %h want 0 0", out_f[0], out_f[1]);
      end
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b000) begin
         err_cnt++;
         $display("FAIL idle_ready: got %b%b%b want 000", ring_rdy[0], loc_rdy[0], ext_rdy[0]);
      end
   endtask

   task automatic test_single_flit();
      loc_f[0] = {1'b1, 1'b1, 16'h0001};
      ext_f[0] = {1'b1, 1'b1, 16'h0002};
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b010) begin
         err_cnt++;
         $display("FAIL single_grant_local: got %b%b%b want 010", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'h0001}) begin
         err_cnt++;
         $display("FAIL single_out_1: got %h want %h", out_f[0], {1'b1, 1'b1, 16'h0001});
      end
      // Local stays valid with a new packet; round-robin must now pick ext.
      loc_f[0] = {1'b1, 1'b1, 16'h0003};
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b001) begin
         err_cnt++;
         $display("FAIL single_grant_ext: got %b%b%b want 001", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'h0002}) begin
         err_cnt++;
         $display("FAIL single_out_2: got %h want %h", out_f[0], {1'b1, 1'b1, 16'h0002});
      end
      ext_f[0] = '0;
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'h0003}) begin
         err_cnt++;
         $display("FAIL single_out_3: got %h want %h", out_f[0], {1'b1, 1'b1, 16'h0003});
      end
      loc_f[0] = '0;
      tick();
      cmp_cnt++;
      if (out_f[0].valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_drain: got valid %b want 0", out_f[0].valid);
      end
   endtask

   task automatic test_worm_lock();
      // Pointer now favours ext; ring is held valid throughout the worm.
      ext_f[0]  = {1'b1, 1'b0, 16'hA000};
      ring_f[0] = {1'b1, 1'b1, 16'h5555};
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b001) begin
         err_cnt++;
         $display("FAIL worm_first_grant: got %b%b%b want 001", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b0, 16'hA000}) begin
         err_cnt++;
         $display("FAIL worm_out_0: got %h want %h", out_f[0], {1'b1, 1'b0, 16'hA000});
      end
      // Bubble from the locked source: ring must stay blocked.
      ext_f[0] = '0;
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0]} !== 2'b00) begin
         err_cnt++;
         $display("FAIL worm_bubble_lock: got ring %b local %b want 0 0", ring_rdy[0],
                  loc_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0].valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL worm_bubble_drain: got valid %b want 0", out_f[0].valid);
      end
      ext_f[0] = {1'b1, 1'b0, 16'hA001};
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], ext_rdy[0]} !== 2'b01) begin
         err_cnt++;
         $display("FAIL worm_mid_grant: got ring %b ext %b want 0 1", ring_rdy[0], ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b0, 16'hA001}) begin
         err_cnt++;
         $display("FAIL worm_out_1: got %h want %h", out_f[0], {1'b1, 1'b0, 16'hA001});
      end
      ext_f[0] = {1'b1, 1'b1, 16'hA002};
      #1;
      cmp_cnt++;
      if (ring_rdy[0] !== 1'b0) begin
         err_cnt++;
         $display("FAIL worm_last_lock: got ring_ready %b want 0", ring_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'hA002}) begin
         err_cnt++;
         $display("FAIL worm_out_2: got %h want %h", out_f[0], {1'b1, 1'b1, 16'hA002});
      end
      ext_f[0] = '0;
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b100) begin
         err_cnt++;
         $display("FAIL worm_release_ring: got %b%b%b want 100", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'h5555}) begin
         err_cnt++;
         $display("FAIL worm_ring_out: got %h want %h", out_f[0], {1'b1, 1'b1, 16'h5555});
      end
      ring_f[0] = '0;
      tick();
   endtask

   task automatic test_backpressure();
      ring_f[0] = {1'b1, 1'b0, 16'hB000};
      #1;
      cmp_cnt++;
      if (ring_rdy[0] !== 1'b1) begin
         err_cnt++;
         $display("FAIL bp_start_grant: got ring_ready %b want 1", ring_rdy[0]);
      end
      tick();
      ring_f[0] = {1'b1, 1'b0, 16'hB001};
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b0, 16'hB001}) begin
         err_cnt++;
         $display("FAIL bp_pre_out: got %h want %h", out_f[0], {1'b1, 1'b0, 16'hB001});
      end
      ring_f[0]  = {1'b1, 1'b0, 16'hB002};
      out_rdy[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         cmp_cnt++;
         if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b000) begin
            err_cnt++;
            $display("FAIL bp_stall_ready[%0d]: got %b%b%b want 000", c, ring_rdy[0],
                     loc_rdy[0], ext_rdy[0]);
         end
         tick();
         cmp_cnt++;
         if (out_f[0] !== {1'b1, 1'b0, 16'hB001}) begin
            err_cnt++;
            $display("FAIL bp_stall_hold[%0d]: got %h want %h", c, out_f[0],
                     {1'b1, 1'b0, 16'hB001});
         end
      end
      out_rdy[0] = 1'b1;
      #1;
      cmp_cnt++;
      if (ring_rdy[0] !== 1'b1) begin
         err_cnt++;
         $display("FAIL bp_resume_ready: got %b want 1", ring_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b0, 16'hB002}) begin
         err_cnt++;
         $display("FAIL bp_resume_out: got %h want %h", out_f[0], {1'b1, 1'b0, 16'hB002});
      end
      ring_f[0] = {1'b1, 1'b1, 16'hB003};
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'hB003}) begin
         err_cnt++;
         $display("FAIL bp_last_out: got %h want %h", out_f[0], {1'b1, 1'b1, 16'hB003});
      end
      ring_f[0] = '0;
      tick();
      cmp_cnt++;
      if (out_f[0].valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL bp_drain: got valid %b want 0", out_f[0].valid);
      end
   endtask

   task automatic test_ring_priority();
      loc_f[1] = {1'b1, 1'b1, 16'hD000};
      for (int k = 0; k < 3; k++) begin
         ring_f[1] = {1'b1, 1'b1, 16'hC000 + 16'(k)};
         #1;
         cmp_cnt++;
         if ({ring_rdy[1], loc_rdy[1], ext_rdy[1]} !== 3'b100) begin
            err_cnt++;
            $display("FAIL prio_ring_grant[%0d]: got %b%b%b want 100", k, ring_rdy[1],
                     loc_rdy[1], ext_rdy[1]);
         end
         tick();
         cmp_cnt++;
         if (out_f[1] !== {1'b1, 1'b1, 16'hC000 + 16'(k)}) begin
            err_cnt++;
            $display("FAIL prio_ring_out[%0d]: got %h want %h", k, out_f[1],
                     {1'b1, 1'b1, 16'hC000 + 16'(k)});
         end
      end
      ring_f[1] = '0;
      #1;
      cmp_cnt++;
      if ({ring_rdy[1], loc_rdy[1], ext_rdy[1]} !== 3'b010) begin
         err_cnt++;
         $display("FAIL prio_bubble_grant: got %b%b%b want 010", ring_rdy[1], loc_rdy[1],
                  ext_rdy[1]);
      end
      tick();
      cmp_cnt++;
      if (out_f[1] !== {1'b1, 1'b1, 16'hD000}) begin
         err_cnt++;
         $display("FAIL prio_local_out: got %h want %h", out_f[1], {1'b1, 1'b1, 16'hD000});
      end
      loc_f[1] = '0;
      tick();
   endtask

   task automatic test_reset_mid_worm();
      loc_f[0] = {1'b1, 1'b0, 16'hE000};
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b010) begin
         err_cnt++;
         $display("FAIL rmw_grant: got %b%b%b want 010", ring_rdy[0], loc_rdy[0], ext_rdy[0]);
      end
      tick();
      loc_f[0] = {1'b1, 1'b0, 16'hE001};
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b0, 16'hE001}) begin
         err_cnt++;
         $display("FAIL rmw_pre_out: got %h want %h", out_f[0], {1'b1, 1'b0, 16'hE001});
      end
      // Asynchronous reset well away from any clock edge.
      loc_f[0] = {1'b1, 1'b0, 16'hE002};
      rst = 1'b1;
      #1;
      cmp_cnt++;
      if (out_f[0] !== 18'h0) begin
         err_cnt++;
         $display("FAIL rmw_async_out: got %h want 0", out_f[0]);
      end
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b000) begin
         err_cnt++;
         $display("FAIL rmw_reset_ready: got %b%b%b want 000", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      loc_f[0] = '0;
      ext_f[0] = {1'b1, 1'b1, 16'hF000};
      rst = 1'b0;
      #1;
      cmp_cnt++;
      if ({ring_rdy[0], loc_rdy[0], ext_rdy[0]} !== 3'b001) begin
         err_cnt++;
         $display("FAIL rmw_ext_grant: got %b%b%b want 001", ring_rdy[0], loc_rdy[0],
                  ext_rdy[0]);
      end
      tick();
      cmp_cnt++;
      if (out_f[0] !== {1'b1, 1'b1, 16'hF000}) begin
         err_cnt++;
         $display("FAIL rmw_ext_out: got %h want %h", out_f[0], {1'b1, 1'b1, 16'hF000});
      end
      ext_f[0] = '0;
      tick();
      cmp_cnt++;
      if (out_f[0].valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL rmw_drain: got valid %b want 0", out_f[0].valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_flit();
      test_worm_lock();
      test_backpressure();
      test_ring_priority();
      test_reset_mid_worm();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
